// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier: FSM states,
// counter sizing and the supported operand width range.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  // Step counter must hold 2*width-1 with a spare bit so it never wraps
  function automatic int cnt_width(input int width);
    return $clog2(2 * width) + 1;
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save cell of the serial-parallel multiplier. It adds the
// partial-product bit, the sum arriving from the next-higher cell and its
// own stored carry. With tc_en set the partial product is inverted, which
// (together with a one-time correction injected by the top) gives the
// multiplicand MSB its negative two's-complement weight.
module spm_csa_cell
  import spm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic mc_bit,
  input  logic x,
  input  logic sum_in,
  input  logic tc_en,
  output logic sum_q,
  output logic sum_d
);

  logic pp;
  logic carry_q;
  logic carry_d;

  // Full-adder of partial product, incoming sum and stored carry
  always_comb begin
    pp      = tc_en ? ~(mc_bit & x) : (mc_bit & x);
    sum_d   = pp ^ sum_in ^ carry_q;
    carry_d = (pp & sum_in) | (pp & carry_q) | (sum_in & carry_q);
  end

  // Sum and carry flops: cleared on reset or a new accept, updated per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (clr) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/spm_mult_param.sv
// Parametrised signed/unsigned serial-parallel multiplier. The multiplicand
// is held in parallel, the multiplier is shifted out LSB first (sign
// extended in signed mode) for 2*WIDTH steps, and each step one product bit
// leaves the LSB cell and enters the top of the product shift register.
module spm_mult_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  import spm_pkg::*;

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(PW - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("spm_mult_param: WIDTH must be within 2..64");
  end

  spm_state_t       state_q;
  spm_state_t       state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mc_q;
  logic [WIDTH-1:0] mp_sr;
  logic             mode_q;
  logic [PW-1:0]    p_q;
  logic             accept;
  logic             run;

  // sum_chain[i] is the registered sum of cell i; the top entry feeds the MSB
  // cell and carries the signed-mode correction on the first step only
  logic [WIDTH:0]   sum_chain;
  logic [WIDTH-1:0] sum_next;
  logic             unused_sums;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign run    = (state_q == RUN);
  assign busy   = run;
  assign done   = (state_q == DONE);
  assign p      = p_q;

  assign sum_chain[WIDTH] = mode_q & (cnt_q == '0);
  assign unused_sums      = ^{sum_chain[0], sum_next[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    spm_csa_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (run),
      .mc_bit (mc_q[i]),
      .x      (mp_sr[0]),
      .sum_in (sum_chain[i+1]),
      .tc_en  ((i == WIDTH - 1) ? mode_q : 1'b0),
      .sum_q  (sum_chain[i]),
      .sum_d  (sum_next[i])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start is only honoured in IDLE or DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_STEP) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept, then per-step counter, multiplier shift and product shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      mc_q   <= '0;
      mp_sr  <= '0;
      mode_q <= 1'b0;
      p_q    <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      mc_q   <= mc;
      mp_sr  <= mp;
      mode_q <= signed_mode;
    end else if (run) begin
      cnt_q  <= cnt_q + CW'(1);
      mp_sr  <= {mode_q & mp_sr[WIDTH-1], mp_sr[WIDTH-1:1]};
      p_q    <= {sum_next[0], p_q[PW-1:1]};
    end
  end

endmodule
